fnd_scan_decoder: RTL
=====================

// Module: fnd_scan_decoder
// PURPOSE
//  Receive-side counterpart of the one-hot-to-7-segment encoder path. Watches a scanned,
//  multiplexed FND bus (active-low segments + active-low digit enables) and reconstructs the
//  digit shown on each position as one-hot and BCD. Used as loopback checker/monitor
//  behind the display driver; glitch-filters scan transitions and flags illegal patterns.
// PARAMETERS
//  NUM_DIGITS     4   number of scanned digit positions (>=1)
//  STABLE_CYCLES  4   consecutive identical samples required before capture (>=1)
// PORTS
//  clk           in   1              system clock, rising edge
//  rst           in   1              synchronous reset, active-high
//  seg_n         in   7              segments, active-low, bit6=g ... bit0=a
//  dig_en_n      in   NUM_DIGITS     digit enables, active-low, one position low when driven
//  digit_onehot  out  NUM_DIGITS*10  per digit one-hot value, bit k = digit k; 0 if blank/err
//  digit_bcd     out  NUM_DIGITS*4   per digit BCD 0-9; 4'hF blank; 4'hE illegal pattern
//  digit_valid   out  NUM_DIGITS     per digit: last capture was a legal digit 0-9
//  frame_valid   out  1              1-cycle pulse: every position captured since last pulse
//  err           out  1              1-cycle pulse: captured pattern not in table
// BEHAVIOUR
//  - Legal patterns: 0=7'h40 1=7'h79 2=7'h24 3=7'h30 4=7'h19 5=7'h12 6=7'h02 7=7'h78
//    8=7'h00 9=7'h10; blank=7'h7F (legal, not an error). Any other value is illegal.
//  - {seg_n,dig_en_n} registered once (s_q) on every clk; all logic works on s_q.
//  - Stability counter: cleared when s_q differs from previous s_q, else increments,
//    saturating at STABLE_CYCLES. Width $clog2(STABLE_CYCLES+1).
//  - FSM: IDLE -> SETTLE when s_q.dig_en_n has exactly one bit low.
//    SETTLE -> HELD when counter == STABLE_CYCLES-1 and s_q unchanged; capture on that edge.
//    SETTLE/HELD -> IDLE when dig_en_n not exactly one-hot-low (none or several low).
//    SETTLE/HELD -> SETTLE (counter cleared) on any change with a new one-hot-low enable.
//    HELD: no further capture until s_q changes (one capture per dwell).
//  - Latency: outputs reflect a new stable value STABLE_CYCLES+1 edges after inputs settle.
//  - Capture on position i: legal digit -> onehot[i]=1<<d, bcd[i]=d, valid[i]=1;
//    blank -> onehot 0, bcd 4'hF, valid 0; illegal -> onehot 0, bcd 4'hE, valid 0, err=1.
//    Other positions' outputs hold.
//  - Frame tracking: seen mask bit i set on capture of position i. When capture completes the
//    mask (all ones including this capture), frame_valid pulses that same edge and mask clears.
//  - Multiple enables low simultaneously (ghosting): never captured, no err, counter cleared.
//  - Reset (any time, mid-dwell included): FSM=IDLE, counter=0, s_q=all ones, seen=0,
//    digit_onehot=0, digit_bcd=all 4'hF, digit_valid=0, frame_valid=0, err=0.
//  - STABLE_CYCLES=1: capture on the first edge a one-hot enable is seen in s_q.
// STRUCTURE
//  - Package fnd_pkg: SEG_0..SEG_9, SEG_BLANK constants; BCD_BLANK=4'hF, BCD_ERR=4'hE;
//    FSM state encodings ST_IDLE/ST_SETTLE/ST_HELD.
//  - Sub-module fnd_pattern_decoder (combinational): seg_n[6:0] -> onehot[9:0], bcd[3:0],
//    is_blank, is_illegal. Top holds input reg, counter, FSM, capture regs, seen mask.
// TESTING
//  1 Reset: hold rst 3 cycles -> bcd all 4'hF, onehot 0, valid 0, frame_valid/err 0.
//  2 STABLE_CYCLES=4, dig_en_n=4'b1110, seg_n=7'h24 for 6 cycles -> bcd[3:0]=2,
//    onehot[9:0]=10'h004, valid[0]=1 on 5th edge after first drive; exactly one capture.
//  3 Scan 4 digits 7'h79,7'h30,7'h12,7'h10 each 8 cycles -> bcd=16'h9531,
//    frame_valid single pulse on 4th capture, none on following dwells until all re-seen.
//  4 Glitch: seg_n 7'h40 for 2 cycles then 7'h00 for 8 -> only 8 captured, no err.
//  5 Illegal 7'h7E on digit 1 stable -> err 1-cycle pulse, bcd[7:4]=4'hE, valid[1]=0;
//    blank 7'h7F -> bcd 4'hF, no err. dig_en_n=4'b1100 stable 10 cycles -> no capture.
//  6 Assert rst mid-SETTLE (2 of 4 cycles) -> all outputs at reset values next edge,
//    capture restarts full STABLE_CYCLES count after rst drops.

Source files
------------

// File: rtl/fnd_pkg.sv
// rtl/fnd_pkg.sv - shared segment patterns, BCD codes and FSM states for the FND scan decoder
package fnd_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [3:0] BCD_ERR   = 4'hE;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HELD   = 2'd2
  } fnd_state_t;

endpackage

// File: rtl/fnd_pattern_decoder.sv
// rtl/fnd_pattern_decoder.sv - combinational active-low 7-segment pattern to one-hot/BCD decoder
module fnd_pattern_decoder
  import fnd_pkg::*;
(
  input  logic [6:0] i_seg_n,
  output logic [9:0] o_onehot,
  output logic [3:0] o_bcd,
  output logic       o_is_blank,
  output logic       o_is_illegal
);

  always_comb begin
    o_onehot     = '0;
    o_bcd        = BCD_ERR;
    o_is_blank   = 1'b0;
    o_is_illegal = 1'b0;
    case (i_seg_n)
      SEG_0:     o_bcd = 4'd0;
      SEG_1:     o_bcd = 4'd1;
      SEG_2:     o_bcd = 4'd2;
      SEG_3:     o_bcd = 4'd3;
      SEG_4:     o_bcd = 4'd4;
      SEG_5:     o_bcd = 4'd5;
      SEG_6:     o_bcd = 4'd6;
      SEG_7:     o_bcd = 4'd7;
      SEG_8:     o_bcd = 4'd8;
      SEG_9:     o_bcd = 4'd9;
      SEG_BLANK: begin
        o_bcd      = BCD_BLANK;
        o_is_blank = 1'b1;
      end
      default:   o_is_illegal = 1'b1;
    endcase
    if (!o_is_blank && !o_is_illegal) o_onehot = 10'd1 << o_bcd;
  end

endmodule

// File: rtl/fnd_scan_decoder.sv
// rtl/fnd_scan_decoder.sv - glitch-filtered capture of a scanned FND bus into per-digit one-hot/BCD
module fnd_scan_decoder
  import fnd_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [6:0]                 seg_n,
  input  logic [NUM_DIGITS-1:0]      dig_en_n,
  output logic [NUM_DIGITS*10-1:0]   digit_onehot,
  output logic [NUM_DIGITS*4-1:0]    digit_bcd,
  output logic [NUM_DIGITS-1:0]      digit_valid,
  output logic                       frame_valid,
  output logic                       err
);

  localparam int             CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0]  CNT_CAP = CW'(STABLE_CYCLES - 1);

  logic [6:0]              r_seg_q;
  logic [NUM_DIGITS-1:0]   r_en_q;
  logic [CW-1:0]           r_cnt;
  fnd_state_t              r_state;
  logic [NUM_DIGITS-1:0]   r_seen;
  logic [NUM_DIGITS*10-1:0] r_onehot;
  logic [NUM_DIGITS*4-1:0] r_bcd;
  logic [NUM_DIGITS-1:0]   r_valid;
  logic                    r_frame_valid;
  logic                    r_err;

  logic [NUM_DIGITS-1:0]   w_en;
  logic                    w_one_low;
  logic                    w_changed;
  logic                    w_capture;
  logic [9:0]              w_dec_onehot;
  logic [3:0]              w_dec_bcd;
  logic                    w_dec_blank;
  logic                    w_dec_illegal;

  fnd_pattern_decoder u_dec (
    .i_seg_n      (r_seg_q),
    .o_onehot     (w_dec_onehot),
    .o_bcd        (w_dec_bcd),
    .o_is_blank   (w_dec_blank),
    .o_is_illegal (w_dec_illegal)
  );

  // "Changed" looks at the sample about to enter s_q, so r_cnt counts edges s_q has held its value.
  assign w_en      = ~r_en_q;
  assign w_one_low = (w_en != '0) && ((w_en & (w_en - NUM_DIGITS'(1))) == '0);
  assign w_changed = {seg_n, dig_en_n} != {r_seg_q, r_en_q};
  assign w_capture = w_one_low && !w_changed && (r_cnt == CNT_CAP) && (r_state != ST_HELD);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg_q       <= '1;
      r_en_q        <= '1;
      r_cnt         <= '0;
      r_state       <= ST_IDLE;
      r_seen        <= '0;
      r_onehot      <= '0;
      r_bcd         <= '1;
      r_valid       <= '0;
      r_frame_valid <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_seg_q       <= seg_n;
      r_en_q        <= dig_en_n;
      r_frame_valid <= 1'b0;
      r_err         <= 1'b0;

      if (w_changed)            r_cnt <= '0;
      else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (w_one_low) r_state <= w_capture ? ST_HELD : ST_SETTLE;
        end
        default: begin
          if (!w_one_low)     r_state <= ST_IDLE;
          else if (w_changed) r_state <= ST_SETTLE;
          else if (w_capture) r_state <= ST_HELD;
        end
      endcase

      if (w_capture) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (w_en[i]) begin
            r_onehot[i*10 +: 10] <= w_dec_onehot;
            r_bcd[i*4 +: 4]      <= w_dec_bcd;
            r_valid[i]           <= !w_dec_blank && !w_dec_illegal;
          end
        end
        r_err <= w_dec_illegal;
        if ((r_seen | w_en) == '1) begin
          r_frame_valid <= 1'b1;
          r_seen        <= '0;
        end else begin
          r_seen <= r_seen | w_en;
        end
      end
    end
  end

  assign digit_onehot = r_onehot;
  assign digit_bcd    = r_bcd;
  assign digit_valid  = r_valid;
  assign frame_valid  = r_frame_valid;
  assign err          = r_err;

endmodule
